// File: rtl/com_fifo_ctrl.sv
// com_fifo_ctrl: byte-wide UART bus controller with TX/RX FIFOs and a start/busy transmit handshake.
// Define COM_IRQ_EN to add the registered irq output and the STATUS[6:4] interrupt enable masks.
//
// state        | meaning
// S_IDLE       | waiting for a queued byte and an idle transmitter
// S_START      | tx_start asserted for this single cycle
// S_WAIT_BUSY  | waiting for tx_busy to rise, gives up after 4 cycles
// S_WAIT_DONE  | waiting for tx_busy to fall
module com_fifo_ctrl #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_addr,
  input  logic       bus_wr,
  input  logic       bus_rd,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_ready,
  input  logic [7:0] rx_data
`ifdef COM_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] TX_PTR_INC = {{TX_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [RX_DEPTH_LOG2:0] RX_PTR_INC = {{RX_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [1:0] TMR_LOAD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } tx_state_e;

  logic wr_data, wr_stat, rd_data, rd_stat;

  assign wr_data = bus_wr && !bus_addr;
  assign wr_stat = bus_wr &&  bus_addr;
  assign rd_data = bus_rd && !bus_addr;
  assign rd_stat = bus_rd &&  bus_addr;

  // TX FIFO
  logic [7:0]             tx_mem_q [TX_DEPTH];
  logic [7:0]             tx_mem_d [TX_DEPTH];
  logic [TX_DEPTH_LOG2:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic                   tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]             tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TX_DEPTH_LOG2-1:0] == tx_rptr_q[TX_DEPTH_LOG2-1:0]) &&
                    (tx_wptr_q[TX_DEPTH_LOG2] != tx_rptr_q[TX_DEPTH_LOG2]);
  assign tx_head  = tx_mem_q[tx_rptr_q[TX_DEPTH_LOG2-1:0]];
  assign tx_push  = wr_data && !tx_full;

  always_comb begin
    tx_mem_d  = tx_mem_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    if (tx_push) begin
      tx_mem_d[tx_wptr_q[TX_DEPTH_LOG2-1:0]] = bus_wdata;
      tx_wptr_d = tx_wptr_q + TX_PTR_INC;
    end
    if (tx_pop) begin
      tx_rptr_d = tx_rptr_q + TX_PTR_INC;
    end
  end

  // RX FIFO; a pop in the same cycle frees the slot a full-FIFO push needs
  logic [7:0]             rx_mem_q [RX_DEPTH];
  logic [7:0]             rx_mem_d [RX_DEPTH];
  logic [RX_DEPTH_LOG2:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic                   rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0]             rx_head;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[RX_DEPTH_LOG2-1:0] == rx_rptr_q[RX_DEPTH_LOG2-1:0]) &&
                    (rx_wptr_q[RX_DEPTH_LOG2] != rx_rptr_q[RX_DEPTH_LOG2]);
  assign rx_head  = rx_mem_q[rx_rptr_q[RX_DEPTH_LOG2-1:0]];
  assign rx_pop   = rd_data && !rx_empty;
  assign rx_push  = rx_ready && (!rx_full || rx_pop);

  always_comb begin
    rx_mem_d  = rx_mem_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    if (rx_push) begin
      rx_mem_d[rx_wptr_q[RX_DEPTH_LOG2-1:0]] = rx_data;
      rx_wptr_d = rx_wptr_q + RX_PTR_INC;
    end
    if (rx_pop) begin
      rx_rptr_d = rx_rptr_q + RX_PTR_INC;
    end
  end

  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (wr_stat && bus_wdata[2]) overrun_d = 1'b0;
    if (rx_ready && rx_full && !rx_pop) overrun_d = 1'b1;
  end

  // TX sequencer
  tx_state_e  state_q, state_d;
  logic [1:0] tmr_q, tmr_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    tx_data_d = tx_data_q;
    tx_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_empty && !tx_busy) begin
          state_d   = S_START;
          tx_data_d = tx_head;
          tx_pop    = 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
        tmr_d   = TMR_LOAD;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmr_q == 2'd0) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - 2'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_start = (state_q == S_START);
  assign tx_data  = tx_data_q;

  logic       tx_idle;
  logic [7:0] status;
  logic [7:0] bus_rdata_q, bus_rdata_d;

  assign tx_idle = tx_empty && (state_q == S_IDLE) && !tx_busy;

`ifdef COM_IRQ_EN
  logic [2:0] irq_mask_q, irq_mask_d;
  logic       irq_q, irq_d;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_stat) irq_mask_d = bus_wdata[6:4];
    irq_d = |(irq_mask_q & {tx_idle, overrun_q, !rx_empty});
  end

  assign status = {1'b0, irq_mask_q, tx_idle, overrun_q, !tx_full, !rx_empty};
  assign irq    = irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_mask_q <= 3'b000;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end
`else
  assign status = {4'b0000, tx_idle, overrun_q, !tx_full, !rx_empty};
`endif

  always_comb begin
    bus_rdata_d = bus_rdata_q;
    if (rd_data) bus_rdata_d = rx_empty ? 8'h00 : rx_head;
    if (rd_stat) bus_rdata_d = status;
  end

  assign bus_rdata = bus_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      overrun_q   <= 1'b0;
      state_q     <= S_IDLE;
      tmr_q       <= 2'd0;
      tx_data_q   <= 8'h00;
      bus_rdata_q <= 8'h00;
    end else begin
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      tx_data_q   <= tx_data_d;
      bus_rdata_q <= bus_rdata_d;
    end
  end

  // storage arrays need no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

endmodule

// File: tb/tb_com_fifo_ctrl.sv
// tb_com_fifo_ctrl: directed bench for com_fifo_ctrl (default 16-entry FIFOs).
// Build with COM_IRQ_EN defined to also exercise the irq output and masks.
module tb_com_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       bus_addr;
  logic       bus_wr;
  logic       bus_rd;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_ready;
  logic [7:0] rx_data;
`ifdef COM_IRQ_EN
  logic       irq;
`endif

  int checks;
  int errors;

  com_fifo_ctrl #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data)
`ifdef COM_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    cycle();
    bus_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d);
    bus_addr = a;
    bus_rd   = 1'b1;
    cycle();
    bus_rd   = 1'b0;
    d        = bus_rdata;
  endtask

  task automatic wait_start(input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (tx_start) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check8(tag, {7'd0, found}, 8'h01);
  endtask

  task automatic count_starts(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      cycle();
      if (tx_start) cnt++;
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         n;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus_addr  = 1'b0;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    bus_wdata = 8'h00;
    tx_busy   = 1'b0;
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    cycle();
    cycle();
    rst = 1'b0;

    // reset state
    check8("rst_rdata", bus_rdata, 8'h00);
    check8("rst_tx_start", {7'd0, tx_start}, 8'h00);
    check8("rst_tx_data", tx_data, 8'h00);
`ifdef COM_IRQ_EN
    check8("rst_irq", {7'd0, irq}, 8'h00);
`endif
    bus_read(1'b1, rd);
    check8("rst_status", rd, 8'h0A);
    bus_read(1'b0, rd);
    check8("rst_data_empty", rd, 8'h00);

    // single byte, start latency and busy handshake
    bus_write(1'b0, 8'h55);
    check8("lat_start_e0", {7'd0, tx_start}, 8'h00);
    cycle();
    check8("lat_start_e1", {7'd0, tx_start}, 8'h01);
    check8("lat_tx_data", tx_data, 8'h55);
    tx_busy = 1'b1;
    cycle();
    check8("start_one_cycle", {7'd0, tx_start}, 8'h00);
    count_starts(10, n);
    check8("no_start_busy", n[7:0], 8'h00);
    tx_busy = 1'b0;
    cycle();
    cycle();
    bus_read(1'b1, rd);
    check8("single_status", rd, 8'h0A);

    // fill TX FIFO while transmitter is busy
    tx_busy = 1'b1;
    cycle();
    for (int i = 0; i < 16; i++) begin
      bus_addr  = 1'b0;
      bus_wdata = i[7:0];
      bus_wr    = 1'b1;
      cycle();
    end
    bus_wr = 1'b0;
    bus_read(1'b1, rd);
    check8("tx_full_status", rd, 8'h00);
    check8("tx_full_no_start", {7'd0, tx_start}, 8'h00);
    bus_write(1'b0, 8'h10);
    bus_read(1'b1, rd);
    check8("tx_drop_status", rd, 8'h00);
    tx_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_start($sformatf("drain_start_%0d", i));
      check8($sformatf("drain_data_%0d", i), tx_data, i[7:0]);
      tx_busy = 1'b1;
      cycle();
      check8($sformatf("drain_single_%0d", i), {7'd0, tx_start}, 8'h00);
      cycle();
      cycle();
      tx_busy = 1'b0;
    end
    count_starts(10, n);
    check8("drain_no_extra", n[7:0], 8'h00);
    bus_read(1'b1, rd);
    check8("drain_status", rd, 8'h0A);

    // RX overrun; 17th byte coincides with an overrun clear (set wins)
    for (int i = 0; i < 16; i++) begin
      rx_ready = 1'b1;
      rx_data  = 8'hA0 + i[7:0];
      cycle();
    end
    rx_data   = 8'hB0;
    bus_addr  = 1'b1;
    bus_wdata = 8'h04;
    bus_wr    = 1'b1;
    cycle();
    rx_ready  = 1'b0;
    bus_wr    = 1'b0;
    bus_read(1'b1, rd);
    check8("ovr_status", rd, 8'h0F);
    for (int i = 0; i < 16; i++) begin
      bus_read(1'b0, rd);
      check8($sformatf("rx_read_%0d", i), rd, 8'hA0 + i[7:0]);
    end
    bus_read(1'b1, rd);
    check8("ovr_sticky", rd, 8'h0E);
    bus_write(1'b1, 8'h04);
    bus_read(1'b0, rd);
    check8("rx_empty_read", rd, 8'h00);
    bus_read(1'b1, rd);
    check8("ovr_cleared", rd, 8'h0A);
    cycle();
    cycle();
    check8("rdata_hold", bus_rdata, 8'h0A);

    // full RX with simultaneous push and pop
    for (int i = 0; i < 16; i++) begin
      rx_ready = 1'b1;
      rx_data  = 8'h10 + i[7:0];
      cycle();
    end
    rx_data  = 8'hC3;
    bus_addr = 1'b0;
    bus_rd   = 1'b1;
    cycle();
    rx_ready = 1'b0;
    bus_rd   = 1'b0;
    check8("pushpop_read", bus_rdata, 8'h10);
    bus_read(1'b1, rd);
    check8("pushpop_status", rd, 8'h0B);
    for (int i = 1; i < 16; i++) begin
      bus_read(1'b0, rd);
      check8($sformatf("pushpop_rd_%0d", i), rd, 8'h10 + i[7:0]);
    end
    bus_read(1'b0, rd);
    check8("pushpop_c3", rd, 8'hC3);
    bus_read(1'b1, rd);
    check8("pushpop_final", rd, 8'h0A);

    // reset while in WAIT_DONE with three bytes queued
    bus_write(1'b0, 8'h31);
    cycle();
    check8("mid_start", {7'd0, tx_start}, 8'h01);
    check8("mid_data", tx_data, 8'h31);
    tx_busy = 1'b1;
    bus_write(1'b0, 8'h32);
    bus_write(1'b0, 8'h33);
    bus_write(1'b0, 8'h34);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check8("mid_rst_data", tx_data, 8'h00);
    count_starts(6, n);
    check8("mid_no_start_busy", n[7:0], 8'h00);
    bus_read(1'b1, rd);
    check8("mid_status_busy", rd, 8'h02);
    tx_busy = 1'b0;
    cycle();
    bus_read(1'b1, rd);
    check8("mid_status_idle", rd, 8'h0A);
    count_starts(6, n);
    check8("mid_fifo_flushed", n[7:0], 8'h00);

`ifdef COM_IRQ_EN
    check8("irq_masked_off", {7'd0, irq}, 8'h00);
    bus_write(1'b1, 8'h40);
    cycle();
    check8("irq_tx_idle", {7'd0, irq}, 8'h01);
    bus_read(1'b1, rd);
    check8("irq_mask_readback", rd, 8'h4A);
    bus_write(1'b1, 8'h10);
    cycle();
    check8("irq_rx_mask_empty", {7'd0, irq}, 8'h00);
    rx_ready = 1'b1;
    rx_data  = 8'h77;
    cycle();
    rx_ready = 1'b0;
    cycle();
    check8("irq_rx_pending", {7'd0, irq}, 8'h01);
    bus_read(1'b0, rd);
    check8("irq_rx_byte", rd, 8'h77);
    cycle();
    check8("irq_rx_cleared", {7'd0, irq}, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/com_fifo_ctrl.md
Name: com_fifo_ctrl

Overview:
- Byte-wide, memory-mapped UART controller between the litecpu peripheral bus and the async transmitter/receiver pair.
- Buffers CPU writes in a TX FIFO and drains them to the transmitter through a start/busy handshake.
- Captures receiver data_ready pulses into an RX FIFO for CPU reads.
- Exposes status and a sticky overrun flag.

Parameters:
TX_DEPTH_LOG2  4  TX FIFO depth = 2**TX_DEPTH_LOG2 entries (min 1)
RX_DEPTH_LOG2  4  RX FIFO depth = 2**RX_DEPTH_LOG2 entries (min 1)

Ports:
clk        in   1  system clock, all logic on posedge
rst        in   1  synchronous, active-high reset
bus_addr   in   1  0 = DATA register, 1 = STATUS register
bus_wr     in   1  write strobe, one cycle per access
bus_rd     in   1  read strobe, one cycle per access
bus_wdata  in   8  write data
bus_rdata  out  8  read data, registered; valid the cycle after bus_rd
tx_start   out  1  one-cycle start pulse to transmitter
tx_data    out  8  byte to transmit; stable while tx_start is high
tx_busy    in   1  transmitter busy; rises the cycle after an accepted start
rx_ready   in   1  one-cycle pulse; rx_data is valid in that cycle
rx_data    in   8  received byte
irq        out  1  only present with COM_IRQ_EN

Behaviour:
- Reset values: bus_rdata=0, tx_start=0, tx_data=0, both FIFOs empty, overrun=0, TX FSM in IDLE, irq=0.
- Reset mid-frame does not abort the transmitter; the FSM re-enters IDLE and will not start a new byte until tx_busy is low.
- FIFOs: circular buffers with read/write pointers one bit wider than the index.
  - empty: pointers equal.
  - full: index bits equal and MSBs differ.
  - Pointers wrap modulo 2**(DEPTH_LOG2+1).
- DATA write (addr 0, bus_wr):
  - Pushes bus_wdata into the TX FIFO if not full.
  - If full, the byte is dropped and no state changes.
- DATA read (addr 0, bus_rd):
  - bus_rdata <= RX FIFO head and pops, if not empty.
  - If empty, bus_rdata <= 0x00 and no pop.
- STATUS read (addr 1, bus_rd): bus_rdata <= {4'b0, tx_idle, overrun, tx_not_full, rx_not_empty}.
  - Bit 0: rx_not_empty.
  - Bit 1: tx_not_full.
  - Bit 2: overrun.
  - Bit 3: tx_idle = TX FIFO empty AND FSM in IDLE AND !tx_busy.
- STATUS write (addr 1, bus_wr): bus_wdata[2]=1 clears overrun; all other bits are ignored.
- bus_wr and bus_rd in the same cycle: both act (independent paths); bus_rdata reflects pre-write state.
- bus_rdata holds its value when no read is issued.
- RX capture:
  - rx_ready with RX FIFO not full: push rx_data.
  - rx_ready with RX FIFO full and no same-cycle pop: byte dropped, overrun <= 1.
  - Full with same-cycle pop and push: both succeed; count unchanged, no overrun.
  - Overrun set and clear in the same cycle: set wins.
- TX FSM, four states:
  - IDLE: if TX FIFO not empty and !tx_busy, go to START, with tx_data <= head and a pop.
  - START: tx_start=1 for exactly one cycle; next state WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. A 4-cycle timeout returns to IDLE (byte considered sent).
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE.
- Latency: write to empty FIFO with idle transmitter → tx_start high 2 cycles after the bus_wr edge (push, IDLE→START).
- Same-cycle CPU push and FSM pop on a 1-entry FIFO are both legal; count stays 1.
- tx_start is never asserted while tx_busy=1.

Optional Feature:
- Macro: COM_IRQ_EN.
- Defined:
  - irq is a registered output, 1 when (rx_not_empty OR overrun OR tx_idle), updated every cycle.
  - STATUS bits [6:4] become enable masks for rx/overrun/tx_idle.
  - Masks are written via STATUS write bits [6:4], reset to 0, and read back in bus_rdata[6:4].
  - irq = OR of (masked condition).
- Undefined: no irq port, no masks; STATUS[7:4] read as 0.

Test Plan:
- Reset then STATUS read → 0x0A (tx_idle=1, tx_not_full=1, no RX data); DATA read → 0x00.
- Write 0x55 to DATA, model busy high 1 cycle after start for 10 cycles → tx_start pulses once, 2 cycles after the write, with tx_data=0x55; STATUS afterwards = 0x0A.
- Write 17 bytes 0x00..0x10 back-to-back while tx_busy is held high → STATUS bit1=0 after 16 writes; 0x10 dropped; on busy release, bytes 0x00..0x0F emerge in order, one start per busy cycle.
- Pulse rx_ready 17 times with 0xA0..0xB0, no reads → overrun=1, STATUS=0x0F. Then 16 DATA reads return 0xA0..0xAF. Writing 0x04 to STATUS clears overrun.
- RX FIFO full, rx_ready with 0xC3 in the same cycle as a DATA read → read returns oldest byte, 0xC3 stored, overrun stays 0.
- Assert rst while FSM is in WAIT_DONE with tx_busy high and 3 bytes queued → FIFO empties, no tx_start while busy; STATUS reads 0x02 until busy drops, then 0x0A.
